// File: rtl/stream_unpacker_pkg.sv
// rtl/stream_unpacker_pkg.sv - shared types and helpers for stream_unpacker
//
// Purpose: state enum for the unpacker FSM and a helper that sizes the word index.
// Ports:   none (package).

package stream_unpacker_pkg;

    // IDLE: no word held on data_out. EMIT: a word is presented on data_out.
    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } su_state_e;

    // Index width: $clog2 of the word count, but never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_unpacker.sv
// rtl/stream_unpacker.sv - splits one wide beat into NUM_WORDS narrow words, word 0 first
//
// Purpose: accepts a packed beat of NUM_WORDS words of DATA_WIDTH bits, holds it,
//          and presents the words one per cycle on a registered valid/ready output.
//          A new beat is accepted in the same cycle the last word leaves, so a
//          continuous stream runs without bubbles.
// Optional feature: define STREAM_UNPACKER_LAST_EN to add data_out_last, a
//          registered flag marking the final word of each beat.
// Ports:
//   clk            clock, rising edge
//   rst            synchronous active-high reset
//   data_in        packed beat, word k at [k*DATA_WIDTH +: DATA_WIDTH]
//   data_in_valid  upstream beat valid
//   data_in_ready  beat accepted this cycle when valid (combinational from data_out_ready)
//   data_out       current word (registered)
//   data_out_valid current word valid (registered)
//   data_out_ready downstream takes the word
//   data_out_last  (STREAM_UNPACKER_LAST_EN only) final word of the beat

module stream_unpacker
    import stream_unpacker_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_WIDTH*NUM_WORDS-1:0]  data_in,
    input  logic                             data_in_valid,
    output logic                             data_in_ready,
    output logic [DATA_WIDTH-1:0]            data_out,
    output logic                             data_out_valid,
    input  logic                             data_out_ready
`ifdef STREAM_UNPACKER_LAST_EN
    ,
    output logic                             data_out_last
`endif
);

    localparam int                IDX_W    = idx_width(NUM_WORDS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_WORDS - 1);

    su_state_e                          state_q, state_d;
    logic [IDX_W-1:0]                   idx_q, idx_d;
    logic [IDX_W-1:0]                   nxt_idx;
    logic [DATA_WIDTH*NUM_WORDS-1:0]    hold_q, hold_d;
    logic [DATA_WIDTH-1:0]              dout_q, dout_d;
    logic                               in_fire;
    logic                               out_fire;

    // Ready while empty, or while the final word of the held beat is leaving,
    // so the next beat lands with no idle cycle in between.
    assign data_in_ready  = (state_q == IDLE) || (data_out_ready && (idx_q == LAST_IDX));
    assign in_fire        = data_in_valid && data_in_ready;
    assign out_fire       = (state_q == EMIT) && data_out_ready;

    assign data_out       = dout_q;
    assign data_out_valid = (state_q == EMIT);

    // Saturate at the last index so the part-select below stays in range,
    // including the single-word case where idx is always 0.
    assign nxt_idx = (idx_q == LAST_IDX) ? idx_q : idx_q + IDX_W'(1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        dout_d  = dout_q;
        if (in_fire) begin
            hold_d  = data_in;
            dout_d  = data_in[DATA_WIDTH-1:0];
            idx_d   = '0;
            state_d = EMIT;
        end else if (out_fire) begin
            if (idx_q == LAST_IDX) begin
                state_d = IDLE;
            end else begin
                dout_d = hold_q[int'(nxt_idx) * DATA_WIDTH +: DATA_WIDTH];
                idx_d  = nxt_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            hold_q  <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            dout_q  <= dout_d;
        end
    end

`ifdef STREAM_UNPACKER_LAST_EN
    logic last_q;

    // Tracks "valid and idx at last word" one step ahead so the flag is a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b0;
        end else if (in_fire) begin
            last_q <= (LAST_IDX == '0);
        end else if (out_fire) begin
            last_q <= (idx_q != LAST_IDX) && (nxt_idx == LAST_IDX);
        end
    end

    assign data_out_last = last_q;
`endif

endmodule

// File: tb/tb_stream_unpacker.sv
// tb/tb_stream_unpacker.sv - self-checking bench for stream_unpacker (4x16 and 1x8 instances)

module tb_stream_unpacker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A: four 16-bit words per beat
    logic [63:0] a_data_in      = '0;
    logic        a_in_valid     = 1'b0;
    logic        a_in_ready;
    logic [15:0] a_data_out;
    logic        a_out_valid;
    logic        a_out_ready    = 1'b0;

    // Instance B: single 8-bit word per beat
    logic [7:0]  b_data_in      = '0;
    logic        b_in_valid     = 1'b0;
    logic        b_in_ready;
    logic [7:0]  b_data_out;
    logic        b_out_valid;
    logic        b_out_ready    = 1'b0;

`ifdef STREAM_UNPACKER_LAST_EN
    logic        a_last;
    logic        b_last;
`endif

    stream_unpacker #(.DATA_WIDTH(16), .NUM_WORDS(4)) u_a (
        .clk            (clk),
        .rst            (rst),
        .data_in        (a_data_in),
        .data_in_valid  (a_in_valid),
        .data_in_ready  (a_in_ready),
        .data_out       (a_data_out),
        .data_out_valid (a_out_valid),
        .data_out_ready (a_out_ready)
`ifdef STREAM_UNPACKER_LAST_EN
        ,
        .data_out_last  (a_last)
`endif
    );

    stream_unpacker #(.DATA_WIDTH(8), .NUM_WORDS(1)) u_b (
        .clk            (clk),
        .rst            (rst),
        .data_in        (b_data_in),
        .data_in_valid  (b_in_valid),
        .data_in_ready  (b_in_ready),
        .data_out       (b_data_out),
        .data_out_valid (b_out_valid),
        .data_out_ready (b_out_ready)
`ifdef STREAM_UNPACKER_LAST_EN
        ,
        .data_out_last  (b_last)
`endif
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] word_of(input logic [63:0] beat, input int k);
        return 16'(beat >> (16 * k));
    endfunction

    task automatic test_reset();
        rst         = 1'b1;
        a_in_valid  = 1'b1;
        a_data_in   = {$urandom, $urandom};
        a_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_data_in   = 8'hA5;
        b_out_ready = 1'b1;
        cyc();
        cyc();
        total++;
        if (a_out_valid !== 1'b0) begin bad++; $display("FAIL reset_a_valid got=%b exp=0", a_out_valid); end
        total++;
        if (a_data_out !== 16'h0) begin bad++; $display("FAIL reset_a_data got=%h exp=0000", a_data_out); end
        total++;
        if (b_out_valid !== 1'b0) begin bad++; $display("FAIL reset_b_valid got=%b exp=0", b_out_valid); end
`ifdef STREAM_UNPACKER_LAST_EN
        total++;
        if (a_last !== 1'b0) begin bad++; $display("FAIL reset_a_last got=%b exp=0", a_last); end
`endif
        rst         = 1'b0;
        a_in_valid  = 1'b0;
        a_out_ready = 1'b0;
        b_in_valid  = 1'b0;
        b_out_ready = 1'b0;
        #1;
        total++;
        if (a_in_ready !== 1'b1) begin bad++; $display("FAIL reset_a_in_ready got=%b exp=1", a_in_ready); end
        cyc();
    endtask

    task automatic test_single_beat();
        logic [15:0] exp_w [4];
        exp_w[0] = 16'h1111; exp_w[1] = 16'h2222; exp_w[2] = 16'h3333; exp_w[3] = 16'h4444;
        a_data_in   = 64'h4444_3333_2222_1111;
        a_in_valid  = 1'b1;
        a_out_ready = 1'b1;
        #1;
        total++;
        if (a_in_ready !== 1'b1) begin bad++; $display("FAIL single_accept_ready got=%b exp=1", a_in_ready); end
        cyc();
        a_in_valid = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (a_out_valid !== 1'b1 || a_data_out !== exp_w[k]) begin
                bad++; $display("FAIL single_word%0d got=%b/%h exp=1/%h", k, a_out_valid, a_data_out, exp_w[k]);
            end
            total++;
            if (a_in_ready !== (k == 3)) begin
                bad++; $display("FAIL single_ready%0d got=%b exp=%b", k, a_in_ready, (k == 3));
            end
`ifdef STREAM_UNPACKER_LAST_EN
            total++;
            if (a_last !== (k == 3)) begin bad++; $display("FAIL single_last%0d got=%b exp=%b", k, a_last, (k == 3)); end
`endif
            cyc();
        end
        total++;
        if (a_out_valid !== 1'b0) begin bad++; $display("FAIL single_idle got=%b exp=0", a_out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] b0, b1;
        logic [15:0] exp_w;
        b0 = {$urandom, $urandom};
        b1 = {$urandom, $urandom};
        a_out_ready = 1'b1;
        a_data_in   = b0;
        a_in_valid  = 1'b1;
        cyc();
        a_data_in = b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            exp_w = (k < 4) ? word_of(b0, k) : word_of(b1, k - 4);
            total++;
            if (a_out_valid !== 1'b1 || a_data_out !== exp_w) begin
                bad++; $display("FAIL b2b_word%0d got=%b/%h exp=1/%h", k, a_out_valid, a_data_out, exp_w);
            end
            total++;
            if (a_in_ready !== (k % 4 == 3)) begin
                bad++; $display("FAIL b2b_ready%0d got=%b exp=%b", k, a_in_ready, (k % 4 == 3));
            end
`ifdef STREAM_UNPACKER_LAST_EN
            total++;
            if (a_last !== (k % 4 == 3)) begin bad++; $display("FAIL b2b_last%0d got=%b exp=%b", k, a_last, (k % 4 == 3)); end
`endif
            cyc();
            if (k == 3) a_in_valid = 1'b0;
        end
        total++;
        if (a_out_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b exp=0", a_out_valid); end
    endtask

    task automatic test_stall();
        logic [63:0] beat;
        beat        = {$urandom, $urandom};
        a_data_in   = beat;
        a_in_valid  = 1'b1;
        a_out_ready = 1'b1;
        cyc();
        a_in_valid = 1'b0;
        cyc();
        // word 1 now held; stall with another beat offered
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_data_in   = {$urandom, $urandom};
        for (int s = 0; s < 3; s++) begin
            total++;
            if (a_out_valid !== 1'b1 || a_data_out !== word_of(beat, 1)) begin
                bad++; $display("FAIL stall_hold%0d got=%b/%h exp=1/%h", s, a_out_valid, a_data_out, word_of(beat, 1));
            end
            total++;
            if (a_in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready%0d got=%b exp=0", s, a_in_ready); end
            cyc();
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        #1;
        for (int k = 1; k < 4; k++) begin
            total++;
            if (a_out_valid !== 1'b1 || a_data_out !== word_of(beat, k)) begin
                bad++; $display("FAIL stall_resume%0d got=%b/%h exp=1/%h", k, a_out_valid, a_data_out, word_of(beat, k));
            end
            cyc();
        end
        total++;
        if (a_out_valid !== 1'b0) begin bad++; $display("FAIL stall_idle got=%b exp=0", a_out_valid); end
    endtask

    task automatic test_reset_midstream();
        a_data_in   = {$urandom | 32'h1, $urandom | 32'h1};
        a_in_valid  = 1'b1;
        a_out_ready = 1'b1;
        cyc();
        a_in_valid = 1'b0;
        cyc();
        cyc();
        // word 2 held
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        total++;
        if (a_out_valid !== 1'b0 || a_data_out !== 16'h0 || a_in_ready !== 1'b1) begin
            bad++; $display("FAIL midreset got v=%b d=%h r=%b exp v=0 d=0000 r=1", a_out_valid, a_data_out, a_in_ready);
        end
        cyc();
        total++;
        if (a_out_valid !== 1'b0) begin bad++; $display("FAIL midreset_discard got=%b exp=0", a_out_valid); end
    endtask

    task automatic test_random_n4();
        logic [15:0] q[$];
        logic        exp_ready;
        rst = 1'b1; cyc(); rst = 1'b0;
        for (int c = 0; c < 500; c++) begin
            a_in_valid  = (c < 480) ? 1'($urandom % 2) : 1'b0;
            a_data_in   = {$urandom, $urandom};
            a_out_ready = (c < 480) ? ($urandom % 4 != 0) : 1'b1;
            #1;
            exp_ready = (q.size() == 0) || (a_out_ready && q.size() == 1);
            total++;
            if (a_out_valid !== (q.size() != 0)) begin
                bad++; $display("FAIL rnd4_valid c=%0d got=%b exp=%b", c, a_out_valid, (q.size() != 0));
            end
            if (q.size() != 0) begin
                total++;
                if (a_data_out !== q[0]) begin bad++; $display("FAIL rnd4_data c=%0d got=%h exp=%h", c, a_data_out, q[0]); end
            end
            total++;
            if (a_in_ready !== exp_ready) begin bad++; $display("FAIL rnd4_ready c=%0d got=%b exp=%b", c, a_in_ready, exp_ready); end
`ifdef STREAM_UNPACKER_LAST_EN
            total++;
            if (a_last !== (q.size() == 1)) begin bad++; $display("FAIL rnd4_last c=%0d got=%b exp=%b", c, a_last, (q.size() == 1)); end
`endif
            if (q.size() != 0 && a_out_ready) void'(q.pop_front());
            if (a_in_valid && exp_ready) begin
                for (int k = 0; k < 4; k++) q.push_back(word_of(a_data_in, k));
            end
            cyc();
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b0;
    endtask

    task automatic test_random_n1();
        logic [7:0] q[$];
        logic       exp_ready;
        int         n_out;
        n_out = 0;
        rst = 1'b1; cyc(); rst = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            b_in_valid  = (c < 990) ? 1'($urandom % 2) : 1'b0;
            b_data_in   = 8'($urandom);
            b_out_ready = (c < 990) ? 1'($urandom % 2) : 1'b1;
            #1;
            exp_ready = (q.size() == 0) || b_out_ready;
            total++;
            if (b_out_valid !== (q.size() != 0)) begin
                bad++; $display("FAIL rnd1_valid c=%0d got=%b exp=%b", c, b_out_valid, (q.size() != 0));
            end
            if (q.size() != 0) begin
                total++;
                if (b_data_out !== q[0]) begin bad++; $display("FAIL rnd1_data c=%0d got=%h exp=%h", c, b_data_out, q[0]); end
            end
            total++;
            if (b_in_ready !== exp_ready) begin bad++; $display("FAIL rnd1_ready c=%0d got=%b exp=%b", c, b_in_ready, exp_ready); end
`ifdef STREAM_UNPACKER_LAST_EN
            total++;
            if (b_last !== (q.size() != 0)) begin bad++; $display("FAIL rnd1_last c=%0d got=%b exp=%b", c, b_last, (q.size() != 0)); end
`endif
            if (q.size() != 0 && b_out_ready) begin
                void'(q.pop_front());
                n_out++;
            end
            if (b_in_valid && exp_ready) q.push_back(b_data_in);
            cyc();
        end
        total++;
        if (q.size() != 0 || n_out == 0) begin
            bad++; $display("FAIL rnd1_drain got left=%0d out=%0d exp left=0 out>0", q.size(), n_out);
        end
        b_in_valid  = 1'b0;
        b_out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_back_to_back();
        test_stall();
        test_reset_midstream();
        test_random_n4();
        test_random_n1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_unpacker.md
STREAM_UNPACKER -- requirements
Module: stream_unpacker

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of one output word.
REQ-002 SHALL have parameter NUM_WORDS, default 4, words per input beat; legal range 1..256.
REQ-003 SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port data_in, input, DATA_WIDTH*NUM_WORDS, packed beat; word k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-006 SHALL have port data_in_valid, input, 1, upstream beat valid.
REQ-007 SHALL have port data_in_ready, output, 1, block accepts beat.
REQ-008 SHALL have port data_out, output, DATA_WIDTH, current word; registered.
REQ-009 SHALL have port data_out_valid, output, 1, word valid; registered.
REQ-010 SHALL have port data_out_ready, input, 1, downstream accepts word.

Function
REQ-011 SHALL transfer a beat when data_in_valid && data_in_ready, and a word when data_out_valid && data_out_ready, both in the same rising edge.
REQ-012 SHALL implement states IDLE (no word held) and EMIT (word held on data_out); data_out_valid SHALL equal (state == EMIT).
REQ-013 SHALL drive data_in_ready = (state == IDLE) || (data_out_ready && idx == NUM_WORDS-1); combinational path from data_out_ready is intentional.
REQ-014 SHALL, on beat accept, store data_in in a holding register, load data_out with word 0, set idx = 0, enter EMIT; first word valid one cycle after accept.
REQ-015 SHALL, on word removal with idx < NUM_WORDS-1, load data_out with held word idx+1 and increment idx.
REQ-016 SHALL, on word removal with idx == NUM_WORDS-1 and a simultaneous beat accept, apply REQ-014 (no bubble); without accept, return to IDLE.
REQ-017 SHALL hold data_out, idx and holding register stable while data_out_valid && !data_out_ready.
REQ-018 SHALL sustain one word per cycle under continuous valid/ready, i.e. one beat per NUM_WORDS cycles.
REQ-019 SHALL, for NUM_WORDS == 1, behave as a one-deep pipeline register with full throughput; idx is then constant 0.
REQ-020 SHALL size idx as $clog2(NUM_WORDS), minimum 1 bit; idx never exceeds NUM_WORDS-1.
REQ-021 SHALL never drop, duplicate or reorder words; output order is word 0 first.

Reset
REQ-022 SHALL, with rst high at a clock edge, set state IDLE, idx 0, data_out 0, data_out_valid 0, holding register 0, regardless of any in-flight beat.
REQ-023 SHALL present data_in_ready = 1 in the first cycle after rst deasserts.
REQ-024 SHALL ignore data_in_valid and data_out_ready during reset cycles.

Configuration
REQ-025 SHALL, when STREAM_UNPACKER_LAST_EN is defined, add output data_out_last (1 bit, registered, reset 0), high exactly while data_out_valid && idx == NUM_WORDS-1.
REQ-026 SHALL, when STREAM_UNPACKER_LAST_EN is undefined, omit data_out_last port and logic; all other behaviour identical.

Structure
REQ-027 SHALL place the state enum type (IDLE, EMIT) in shared package stream_unpacker_pkg.
REQ-028 SHALL be a single module with no sub-modules; word selection is an indexed part-select of the holding register.

Verification
REQ-029 SHALL cover: after reset, data_in=0x44443333_22221111_..., NUM_WORDS=4, DATA_WIDTH=16 style beat 0x4444_3333_2222_1111 with out_ready=1 -> data_out 0x1111,0x2222,0x3333,0x4444 on four consecutive cycles, first one cycle after accept.
REQ-030 SHALL cover: two beats back-to-back, data_out_ready=1 always -> 8 words with no gap, data_in_ready high on cycle of word 3 removal only.
REQ-031 SHALL cover: data_out_ready low for 3 cycles while word 1 held -> data_out stays word 1, data_in_ready 0, no word lost.
REQ-032 SHALL cover: rst asserted while idx == 2 -> next cycle data_out_valid 0, data_out 0, data_in_ready 1; remaining words discarded.
REQ-033 SHALL cover: NUM_WORDS=1, random valid/ready for 1000 cycles -> output sequence equals input sequence, reference-model scoreboard.
REQ-034 SHALL cover: STREAM_UNPACKER_LAST_EN defined -> data_out_last high only on word 3 of each beat; undefined build compiles without the port.
